// File: rtl/wsa_adc_frontend_pkg.sv
// Shared definitions for the ADC front end: register addresses, RX mux select
// codes and reset values, and the mux routing helper.
package wsa_adc_frontend_pkg;

    localparam logic [6:0] MUX_ADDR      = 7'd8;
    localparam logic [6:0] DCO_EN_ADDR   = 7'd9;
    localparam logic [6:0] OFFSET_A_ADDR = 7'd10;
    localparam logic [6:0] OFFSET_B_ADDR = 7'd11;

    localparam int RSSI_SHIFT = 10;

    localparam logic [31:0] MUX_RESET = 32'h0000_0042;

    typedef enum logic [1:0] {
        SEL_CORR_A = 2'd0,
        SEL_CORR_B = 2'd1,
        SEL_ZERO_2 = 2'd2,
        SEL_ZERO_3 = 2'd3
    } mux_sel_e;

    function automatic logic [15:0] mux_route(input logic [1:0] sel,
                                              input logic [15:0] corr_a,
                                              input logic [15:0] corr_b);
        case (mux_sel_e'(sel))
            SEL_CORR_A: mux_route = corr_a;
            SEL_CORR_B: mux_route = corr_b;
            default:    mux_route = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/wsa_dc_offset.sv
// One channel's DC-offset removal: offset integrator, saturating subtract and
// the corrected-sample register.
module wsa_dc_offset
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        dco_en,
    input  logic        load_en,
    input  logic [15:0] load_val,
    input  logic [15:0] adc,
    output logic [15:0] corr
);

    logic [31:0] acc_q, acc_d;
    logic [15:0] corr_q, corr_d;
    logic [16:0] diff;
    logic [15:0] sat;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        diff = {adc[15], adc} - {acc_q[31], acc_q[31:16]};
        // A sign mismatch between bits 16 and 15 means the 17-bit result left 16-bit range.
        if (diff[16] != diff[15])
            sat = diff[16] ? 16'h8000 : 16'h7FFF;
        else
            sat = diff[15:0];

        acc_d  = acc_q;
        corr_d = corr_q;
        if (enable) begin
            corr_d = sat;
            if (dco_en)
                acc_d = acc_q + {{16{sat[15]}}, sat};
        end
        if (load_en)
            acc_d = {load_val, 16'h0000};
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q  <= '0;
            corr_q <= '0;
        end else begin
            acc_q  <= acc_d;
            corr_q <= corr_d;
        end
    end

    assign corr = corr_q;

endmodule

// File: rtl/wsa_adc_frontend.sv
// Dual-channel ADC front end: widen, DC-offset correct, route to DDC I/Q, and
// report channel-A RSSI/overload when built with WSA_ADC_RSSI_EN.
module wsa_adc_frontend
    import wsa_adc_frontend_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        serial_strobe,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic [11:0] rx_a_a,
    input  logic [11:0] rx_b_a,
    output logic [15:0] ddc0_in_i,
    output logic [15:0] ddc0_in_q,
    output logic [3:0]  rx_numchan,
    output logic [31:0] rssi_0
);

    logic [31:0] mux_q, mux_d;
    logic [1:0]  dco_en_q, dco_en_d;
    logic [15:0] adc_a_q, adc_a_d;
    logic [15:0] adc_b_q, adc_b_d;
    logic        load_a, load_b;
    logic [15:0] corr_a, corr_b;

    always_comb begin
        mux_d    = mux_q;
        dco_en_d = dco_en_q;
        if (serial_strobe && serial_addr == MUX_ADDR)
            mux_d = serial_data;
        if (serial_strobe && serial_addr == DCO_EN_ADDR)
            dco_en_d = serial_data[1:0];

        adc_a_d = adc_a_q;
        adc_b_d = adc_b_q;
        if (enable) begin
            adc_a_d = {rx_a_a[11], rx_a_a, 3'b000};
            adc_b_d = {rx_b_a[11], rx_b_a, 3'b000};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mux_q    <= MUX_RESET;
            dco_en_q <= '0;
            adc_a_q  <= '0;
            adc_b_q  <= '0;
        end else begin
            mux_q    <= mux_d;
            dco_en_q <= dco_en_d;
            adc_a_q  <= adc_a_d;
            adc_b_q  <= adc_b_d;
        end
    end

    assign load_a = serial_strobe && (serial_addr == OFFSET_A_ADDR);
    assign load_b = serial_strobe && (serial_addr == OFFSET_B_ADDR);

    wsa_dc_offset u_dco_a (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .dco_en   (dco_en_q[0]),
        .load_en  (load_a),
        .load_val (serial_data[15:0]),
        .adc      (adc_a_q),
        .corr     (corr_a)
    );

    wsa_dc_offset u_dco_b (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .dco_en   (dco_en_q[1]),
        .load_en  (load_b),
        .load_val (serial_data[15:0]),
        .adc      (adc_b_q),
        .corr     (corr_b)
    );

    assign ddc0_in_i  = mux_route(mux_q[5:4], corr_a, corr_b);
    assign ddc0_in_q  = mux_route(mux_q[7:6], corr_a, corr_b);
    assign rx_numchan = mux_q[3:0];

`ifdef WSA_ADC_RSSI_EN
    logic [25:0] rssi_acc_q, rssi_acc_d;
    logic [25:0] ovl_acc_q, ovl_acc_d;
    logic [11:0] raw_a;
    logic [11:0] abs_a;
    logic        over_a;

    // The stage-1 register carries the raw sample in bits [14:3].
    always_comb begin
        raw_a = adc_a_q[14:3];
        if (!raw_a[11])
            abs_a = raw_a;
        else if (raw_a == 12'h800)
            abs_a = 12'h7FF;
        else
            abs_a = 12'd0 - raw_a;
        over_a = (raw_a == 12'h7FF) || (raw_a == 12'h800);

        rssi_acc_d = rssi_acc_q;
        ovl_acc_d  = ovl_acc_q;
        if (enable) begin
            rssi_acc_d = rssi_acc_q + {14'd0, abs_a} - (rssi_acc_q >> RSSI_SHIFT);
            ovl_acc_d  = ovl_acc_q + (over_a ? 26'h000_FFFF : 26'h0)
                         - (ovl_acc_q >> RSSI_SHIFT);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rssi_acc_q <= '0;
            ovl_acc_q  <= '0;
        end else begin
            rssi_acc_q <= rssi_acc_d;
            ovl_acc_q  <= ovl_acc_d;
        end
    end

    assign rssi_0 = {ovl_acc_q[25:10], rssi_acc_q[25:10]};
`else
    assign rssi_0 = 32'h0;
`endif

endmodule

// File: tb/tb_wsa_adc_frontend.sv
// Directed self-checking bench for wsa_adc_frontend; expected values are
// hand-computed from the sample scaling, offset and mux rules.
module tb_wsa_adc_frontend;
    import wsa_adc_frontend_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        serial_strobe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic [11:0] rx_a_a;
    logic [11:0] rx_b_a;
    logic [15:0] ddc0_in_i;
    logic [15:0] ddc0_in_q;
    logic [3:0]  rx_numchan;
    logic [31:0] rssi_0;

    int n_checks = 0;
    int n_pass   = 0;

    always #10 clock = ~clock;

    wsa_adc_frontend dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .serial_strobe (serial_strobe),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .rx_a_a        (rx_a_a),
        .rx_b_a        (rx_b_a),
        .ddc0_in_i     (ddc0_in_i),
        .ddc0_in_q     (ddc0_in_q),
        .rx_numchan    (rx_numchan),
        .rssi_0        (rssi_0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic reg_write(input logic [6:0] addr, input logic [31:0] data);
        serial_strobe = 1'b1;
        serial_addr   = addr;
        serial_data   = data;
        tick(1);
        serial_strobe = 1'b0;
    endtask

    initial begin
        logic signed [15:0] conv;

        reset = 1'b1; enable = 1'b1; serial_strobe = 1'b0;
        serial_addr = '0; serial_data = '0; rx_a_a = '0; rx_b_a = '0;
        tick(2);
        reset = 1'b0;
        check("reset_i", {16'd0, ddc0_in_i}, 32'h0);
        check("reset_q", {16'd0, ddc0_in_q}, 32'h0);
        check("reset_numchan", {28'd0, rx_numchan}, 32'd2);
        check("reset_rssi", rssi_0, 32'h0);

        rx_a_a = 12'h100; rx_b_a = 12'hF00;
        tick(2);
        check("basic_i", {16'd0, ddc0_in_i}, 32'h0800);
        check("basic_q", {16'd0, ddc0_in_q}, 32'hF800);
        check("basic_numchan", {28'd0, rx_numchan}, 32'd2);

        enable = 1'b0; rx_a_a = 12'h300;
        tick(5);
        check("freeze_i", {16'd0, ddc0_in_i}, 32'h0800);
        enable = 1'b1;
        tick(2);
        check("resume_i", {16'd0, ddc0_in_i}, 32'h1800);

        rx_a_a = 12'h100;
        reg_write(OFFSET_A_ADDR, 32'h0000_0100);
        tick(1);
        check("offset_i", {16'd0, ddc0_in_i}, 32'h0700);

        reg_write(MUX_ADDR, 32'h0000_0014);
        check("swap_numchan", {28'd0, rx_numchan}, 32'd4);
        check("swap_i", {16'd0, ddc0_in_i}, 32'hF800);
        check("swap_q", {16'd0, ddc0_in_q}, 32'h0700);
        reg_write(MUX_ADDR, 32'h0000_0042);

        rx_a_a = 12'h7FF;
        reg_write(OFFSET_A_ADDR, 32'h0000_8000);
        tick(2);
        check("sat_pos", {16'd0, ddc0_in_i}, 32'h7FFF);
        rx_a_a = 12'h800;
        reg_write(OFFSET_A_ADDR, 32'h0000_7FFF);
        tick(2);
        check("sat_neg", {16'd0, ddc0_in_i}, 32'h8000);

        reg_write(MUX_ADDR, 32'h0000_00A2);
        check("zero_i", {16'd0, ddc0_in_i}, 32'h0);
        check("zero_q", {16'd0, ddc0_in_q}, 32'h0);
        reg_write(MUX_ADDR, 32'h0000_0042);

        rx_a_a = 12'h200;
        reg_write(OFFSET_A_ADDR, 32'h0000_1000);
        reg_write(DCO_EN_ADDR, 32'h0000_0001);
        tick(100);
        check("dco_hold_i", {16'd0, ddc0_in_i}, 32'h0);

        // Integrator time constant is 65536 clocks: after 3000 clocks about 183 LSB removed.
        reg_write(OFFSET_A_ADDR, 32'h0000_0000);
        tick(3000);
        conv = ddc0_in_i;
        check("dco_converging", {31'd0, (conv >= 16'sd3850) && (conv <= 16'sd3960)}, 32'd1);
        check("dco_off_q", {16'd0, ddc0_in_q}, 32'hF800);

        reset = 1'b1;
        serial_strobe = 1'b1; serial_addr = MUX_ADDR; serial_data = 32'h0000_0014;
        tick(1);
        reset = 1'b0; serial_strobe = 1'b0;
        check("rst_prio_numchan", {28'd0, rx_numchan}, 32'd2);
        check("rst_mid_i", {16'd0, ddc0_in_i}, 32'h0);
        check("rst_mid_q", {16'd0, ddc0_in_q}, 32'h0);

        for (int k = 0; k < 12000; k++) begin
            rx_a_a = k[0] ? 12'h7FF : 12'h800;
            tick(1);
        end
        enable = 1'b0; rx_a_a = 12'h000;
        tick(50);
`ifdef WSA_ADC_RSSI_EN
        check("rssi_level", {31'd0, (rssi_0[15:0] >= 16'd2026) && (rssi_0[15:0] <= 16'd2047)}, 32'd1);
        check("ovl_level", {31'd0, rssi_0[31:16] >= 16'hFD70}, 32'd1);
        enable = 1'b1;
        tick(1000);
        check("rssi_decay", {31'd0, rssi_0[15:0] < 16'd1000}, 32'd1);
`else
        check("rssi_tied", rssi_0, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
